// File: rtl/pipe_exec_if.sv
// Request/result handshake bundle between an issuing stage and pipe_exec_unit.
interface pipe_exec_if #(
  parameter int unsigned DATA_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        op;
  logic [DATA_W-1:0] src1;
  logic [DATA_W-1:0] src2;
  logic [DATA_W-1:0] imm_val;
  logic [DATA_W-1:0] mem_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_zero;
  logic              out_carry;
  logic              busy;

  modport master (
    output in_valid, op, src1, src2, imm_val, mem_data, out_ready,
    input  in_ready, out_valid, out_data, out_zero, out_carry, busy
  );

  modport slave (
    input  in_valid, op, src1, src2, imm_val, mem_data, out_ready,
    output in_ready, out_valid, out_data, out_zero, out_carry, busy
  );
endinterface

// File: rtl/pipe_exec_unit.sv
// Single-issue execution unit: 1-cycle ALU/load ops, iterative shift-add multiply,
// result held in an output register until the consumer takes it.
module pipe_exec_unit #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned SHAMT_W = $clog2(DATA_W)
) (
  input  logic       clk,
  input  logic       rst_n,
  pipe_exec_if.slave bus
);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SHL = 4'd5;
  localparam logic [3:0] OP_SHR = 4'd6;
  localparam logic [3:0] OP_MUL = 4'd7;
  localparam logic [3:0] OP_LI  = 4'd8;
  localparam logic [3:0] OP_LW  = 4'd9;

  localparam logic [SHAMT_W-1:0] CNT_LAST = SHAMT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [SHAMT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]   mcand_q, mcand_d;
  logic [DATA_W-1:0]   mplier_q, mplier_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                zero_q, zero_d;
  logic                carry_q, carry_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;

  logic                in_ready_c;
  logic                accept;
  logic [DATA_W:0]     sum_w;
  logic [DATA_W:0]     diff_w;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_carry;
  logic [DATA_W-1:0]   acc_next;
  logic [SHAMT_W-1:0]  shamt;

  assign in_ready_c = (state_q == S_IDLE) || ((state_q == S_HOLD) && bus.out_ready);
  assign accept     = bus.in_valid && in_ready_c;
  assign shamt      = bus.src2[SHAMT_W-1:0];

  // Single-cycle result for every op except MUL (borrow = top bit of the widened difference)
  always_comb begin
    sum_w     = {1'b0, bus.src1} + {1'b0, bus.src2};
    diff_w    = {1'b0, bus.src1} - {1'b0, bus.src2};
    alu_res   = '0;
    alu_carry = 1'b0;
    case (bus.op)
      OP_ADD: begin
        alu_res   = sum_w[DATA_W-1:0];
        alu_carry = sum_w[DATA_W];
      end
      OP_SUB: begin
        alu_res   = diff_w[DATA_W-1:0];
        alu_carry = diff_w[DATA_W];
      end
      OP_AND:  alu_res = bus.src1 & bus.src2;
      OP_OR:   alu_res = bus.src1 | bus.src2;
      OP_XOR:  alu_res = bus.src1 ^ bus.src2;
      OP_SHL:  alu_res = bus.src1 << shamt;
      OP_SHR:  alu_res = bus.src1 >> shamt;
      OP_LI:   alu_res = bus.imm_val;
      OP_LW:   alu_res = bus.mem_data;
      default: alu_res = '0;
    endcase
  end

  // One shift-add step: the multiplier LSB gates the shifted multiplicand into the accumulator
  assign acc_next = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  // Next-state and registered-output logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    data_d   = data_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    valid_d  = valid_q;
    busy_d   = busy_q;

    case (state_q)
      S_IDLE, S_HOLD: begin
        if (accept) begin
          if (bus.op == OP_MUL) begin
            state_d  = S_MUL;
            cnt_d    = '0;
            acc_d    = '0;
            mcand_d  = bus.src1;
            mplier_d = bus.src2;
            valid_d  = 1'b0;
            busy_d   = 1'b1;
          end else begin
            state_d  = S_HOLD;
            data_d   = alu_res;
            zero_d   = (alu_res == '0);
            carry_d  = alu_carry;
            valid_d  = 1'b1;
            busy_d   = 1'b0;
          end
        end else if (state_q == S_HOLD && bus.out_ready) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
        end
      end
      S_MUL: begin
        acc_d    = acc_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + SHAMT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = S_HOLD;
          cnt_d   = '0;
          data_d  = acc_next;
          zero_d  = (acc_next == '0);
          carry_d = 1'b0;
          valid_d = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      data_q   <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      data_q   <= data_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_zero  = zero_q;
  assign bus.out_carry = carry_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_pipe_exec_unit.sv
// Directed self-checking bench for pipe_exec_unit at DATA_W=16.
module tb_pipe_exec_unit;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  pipe_exec_if #(.DATA_W(16)) ifc ();

  pipe_exec_unit #(.DATA_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] imm, input logic [15:0] mem);
    ifc.in_valid = 1'b1;
    ifc.op       = o;
    ifc.src1     = a;
    ifc.src2     = b;
    ifc.imm_val  = imm;
    ifc.mem_data = mem;
    tick();
    ifc.in_valid = 1'b0;
  endtask

  task automatic expect_res(input string tag, input logic [15:0] d, input logic z, input logic c);
    chk({tag, ".valid"}, 64'(ifc.out_valid), 64'd1);
    chk({tag, ".data"},  64'(ifc.out_data),  64'(d));
    chk({tag, ".zero"},  64'(ifc.out_zero),  64'(z));
    chk({tag, ".carry"}, 64'(ifc.out_carry), 64'(c));
  endtask

  initial begin
    int busy_cycles;
    int first_valid;
    int ready_bad;

    n_checks = 0;
    n_pass   = 0;
    rst_n        = 1'b0;
    ifc.in_valid = 1'b0;
    ifc.op       = 4'd0;
    ifc.src1     = '0;
    ifc.src2     = '0;
    ifc.imm_val  = '0;
    ifc.mem_data = '0;
    ifc.out_ready = 1'b1;

    repeat (2) tick();
    chk("rst.out_valid", 64'(ifc.out_valid), 64'd0);
    chk("rst.out_data",  64'(ifc.out_data),  64'd0);
    chk("rst.out_zero",  64'(ifc.out_zero),  64'd0);
    chk("rst.out_carry", 64'(ifc.out_carry), 64'd0);
    chk("rst.busy",      64'(ifc.busy),      64'd0);
    rst_n = 1'b1;
    tick();
    chk("rst.in_ready", 64'(ifc.in_ready), 64'd1);

    // Single-cycle ops, issued back to back
    issue(4'd0, 16'hFFFF, 16'h0001, 16'h0, 16'h0);
    expect_res("add_wrap", 16'h0000, 1'b1, 1'b1);
    issue(4'd1, 16'h0003, 16'h0005, 16'h0, 16'h0);
    expect_res("sub_borrow", 16'hFFFE, 1'b0, 1'b1);
    issue(4'd9, 16'h0, 16'h0, 16'h0, 16'h1234);
    expect_res("lw", 16'h1234, 1'b0, 1'b0);
    issue(4'd0, 16'h1234, 16'h1111, 16'h0, 16'h0);
    expect_res("add", 16'h2345, 1'b0, 1'b0);
    issue(4'd2, 16'hF0F0, 16'h3C3C, 16'h0, 16'h0);
    expect_res("and", 16'h3030, 1'b0, 1'b0);
    issue(4'd3, 16'hF0F0, 16'h3C3C, 16'h0, 16'h0);
    expect_res("or", 16'hFCFC, 1'b0, 1'b0);
    issue(4'd4, 16'hF0F0, 16'h3C3C, 16'h0, 16'h0);
    expect_res("xor", 16'hCCCC, 1'b0, 1'b0);
    issue(4'd5, 16'h00F1, 16'h0004, 16'h0, 16'h0);
    expect_res("shl", 16'h0F10, 1'b0, 1'b0);
    issue(4'd6, 16'hF000, 16'h0013, 16'h0, 16'h0);
    expect_res("shr_amt_masked", 16'h1E00, 1'b0, 1'b0);
    issue(4'd8, 16'h0, 16'h0, 16'h00A5, 16'h0);
    expect_res("li", 16'h00A5, 1'b0, 1'b0);
    issue(4'd12, 16'h0001, 16'h0001, 16'h0, 16'h0);
    expect_res("op_reserved", 16'h0000, 1'b1, 1'b0);
    tick();
    chk("hold_to_idle.valid", 64'(ifc.out_valid), 64'd0);
    chk("idle.data_retained", 64'(ifc.out_data), 64'd0);

    // Multiply: operands changed after accept must be ignored
    issue(4'd7, 16'h00FF, 16'h0101, 16'h0, 16'h0);
    ifc.src1 = 16'h0000;
    ifc.src2 = 16'h0000;
    busy_cycles = 0;
    first_valid = 0;
    ready_bad   = 0;
    for (int k = 0; k < 20; k++) begin
      if (ifc.out_valid) begin
        first_valid = k;
        break;
      end
      if (ifc.busy) busy_cycles++;
      if (ifc.in_ready) ready_bad++;
      tick();
    end
    chk("mul.latency",     64'(first_valid), 64'd16);
    chk("mul.busy_cycles", 64'(busy_cycles), 64'd16);
    chk("mul.in_ready_lo", 64'(ready_bad),   64'd0);
    chk("mul.busy_done",   64'(ifc.busy),    64'd0);
    expect_res("mul", 16'hFFFF, 1'b0, 1'b0);
    tick();

    // Backpressure: result held, pending request not taken until out_ready
    ifc.out_ready = 1'b0;
    issue(4'd0, 16'h0010, 16'h0020, 16'h0, 16'h0);
    expect_res("bp.first", 16'h0030, 1'b0, 1'b0);
    ifc.in_valid = 1'b1;
    ifc.op       = 4'd0;
    ifc.src1     = 16'h0001;
    ifc.src2     = 16'h0001;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp.data_stable", 64'(ifc.out_data),  64'h0030);
      chk("bp.in_ready_lo", 64'(ifc.in_ready),  64'd0);
    end
    ifc.out_ready = 1'b1;
    #1;
    chk("bp.in_ready_hi", 64'(ifc.in_ready), 64'd1);
    tick();
    ifc.in_valid = 1'b0;
    expect_res("bp.second", 16'h0002, 1'b0, 1'b0);
    tick();
    chk("bp.drain", 64'(ifc.out_valid), 64'd0);

    // Streaming: one ADD result per cycle
    for (int i = 0; i < 8; i++) begin
      ifc.in_valid = 1'b1;
      ifc.op       = 4'd0;
      ifc.src1     = 16'(i);
      ifc.src2     = 16'h0100;
      tick();
      chk("stream.valid", 64'(ifc.out_valid), 64'd1);
      chk("stream.data",  64'(ifc.out_data),  64'(16'h0100 + 16'(i)));
    end
    ifc.in_valid = 1'b0;
    tick();

    // Reset in the middle of a multiply
    issue(4'd7, 16'h0003, 16'h0004, 16'h0, 16'h0);
    repeat (7) tick();
    chk("midmul.busy_before", 64'(ifc.busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midmul.busy",      64'(ifc.busy),      64'd0);
    chk("midmul.out_valid", 64'(ifc.out_valid), 64'd0);
    chk("midmul.out_data",  64'(ifc.out_data),  64'd0);
    chk("midmul.out_zero",  64'(ifc.out_zero),  64'd0);
    chk("midmul.out_carry", 64'(ifc.out_carry), 64'd0);
    chk("midmul.in_ready",  64'(ifc.in_ready),  64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("midmul.ready_after", 64'(ifc.in_ready), 64'd1);
    issue(4'd0, 16'h0002, 16'h0003, 16'h0, 16'h0);
    expect_res("after_rst.add", 16'h0005, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_exec_unit.md
PIPE_EXEC_UNIT -- requirements
Module: pipe_exec_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 16: datapath width, legal range 4..64.
REQ-002 SHALL have parameter SHAMT_W = clog2(DATA_W) (derived): shift-amount width.
REQ-003 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1: operation request.
REQ-006 SHALL have port in_ready, output, 1: unit can accept a request this cycle.
REQ-007 SHALL have port op, input, 4: operation code (REQ-014).
REQ-008 SHALL have port src1, input, DATA_W: operand A.
REQ-009 SHALL have port src2, input, DATA_W: operand B.
REQ-010 SHALL have port imm_val, input, DATA_W: immediate for LI.
REQ-011 SHALL have port mem_data, input, DATA_W: memory read data for LW.
REQ-012 SHALL have ports out_valid (output, 1: result held) and out_ready (input, 1: consumer takes result).
REQ-013 SHALL have ports out_data (output, DATA_W: result), out_zero (output, 1: out_data==0), out_carry (output, 1: carry/borrow) and busy (output, 1: multiply in progress).

Function
REQ-014 SHALL decode op as follows:
- 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR;
- 5 SHL, 6 SHR (logical, amount src2[SHAMT_W-1:0]);
- 7 MUL (low DATA_W bits, unsigned);
- 8 LI (imm_val), 9 LW (mem_data);
- 10..15 result 0, carry 0.
REQ-015 SHALL compute carry as ADD carry-out of the DATA_W-bit sum and SUB borrow (src1<src2 unsigned); all other ops carry 0; arithmetic wraps modulo 2^DATA_W.
REQ-016 SHALL implement FSM states IDLE, MUL, HOLD; reset state IDLE.
REQ-017 SHALL accept a request on a rising edge where in_valid && in_ready; op and operands are sampled only at that edge, and later input changes are ignored.
REQ-018 SHALL drive in_ready = (state==IDLE) || (state==HOLD && out_ready); it is 0 in MUL.
REQ-019 SHALL, for an accepted non-MUL op, register the result, carry and zero and enter HOLD, so out_valid is 1 in the cycle after the accepting edge (latency 1).
REQ-020 SHALL, for an accepted MUL, enter MUL with iteration counter 0 and use shift-add, one multiplier bit per cycle; after DATA_W iterations it registers the product and enters HOLD (out_valid rises exactly DATA_W edges after acceptance).
REQ-021 SHALL assert busy exactly while state==MUL.
REQ-022 SHALL hold out_data, out_zero and out_carry stable while out_valid && !out_ready.
REQ-023 SHALL, in HOLD with out_ready=1: load a new result if in_valid=1 (back-to-back, throughput 1 op/cycle for non-MUL, remain HOLD or go MUL); otherwise go to IDLE.
REQ-024 SHALL deassert out_valid in IDLE and MUL; out_data retains its last value outside HOLD.

Reset
REQ-025 SHALL, on rst_n low at any time including mid-MUL, immediately force state IDLE and counter 0, and drive out_valid, out_data, out_zero, out_carry and busy to 0, abandoning any operation in flight.
REQ-026 SHALL present in_ready=1 on the first cycle after rst_n deassertion.

Verification
REQ-027 SHALL cover ADD, DATA_W=16: src1=FFFF, src2=0001 -> next cycle out_valid=1, out_data=0000, out_carry=1, out_zero=1.
REQ-028 SHALL cover SUB: 0003-0005 -> out_data=FFFE, out_carry=1, out_zero=0; LW mem_data=1234 -> out_data=1234.
REQ-029 SHALL cover MUL: 00FF*0101 -> busy=1 for 16 cycles, in_ready=0 throughout, out_data=FFFF exactly 16 edges after accept.
REQ-030 SHALL cover backpressure: out_ready=0 for 5 cycles with in_valid=1 -> out_data stable, in_ready=0, no request lost; out_ready=1 -> next request accepted the same edge.
REQ-031 SHALL cover streaming: 8 consecutive ADDs with out_ready=1 -> 8 results on 8 consecutive cycles, in order.
REQ-032 SHALL cover reset at MUL iteration 7 -> all outputs 0 and state IDLE immediately; a following ADD 0002+0003 -> 0005.
